// File: rtl/mips_pkg.sv
// Shared constants for the 16-bit pipelined MIPS: widths, ALU operation
// codes and the sequential multiplier state encoding.
package mips_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle over DATA_W cycles,
// then a single DONE cycle while the product is handed to the EX/MEM register.
module seq_multiplier #(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  mul_state_t        state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort wins over every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)             state_nxt = ST_BUSY;
      ST_BUSY: if (count == LAST_CNT) state_nxt = ST_DONE;
      ST_DONE:                        state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Operand load on launch, then one shift-add step per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (state == ST_BUSY && !abort) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= {mcand[DATA_W-2:0], 1'b0};
      mplier <= {1'b0, mplier[DATA_W-1:1]};
      count  <= count + 1'b1;
    end
  end

  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU, branch target adder, sequential multiply with
// pipeline stall, and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     read_data_1,
  input  logic [DATA_W-1:0]     read_data_2,
  input  logic [DATA_W-1:0]     sign_ext_imm,
  input  logic [DATA_W-1:0]     pc_plus_2,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  RegDst,
  input  logic                  ALUSrc,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  Branch,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [2:0]            ALUOp,
  input  logic                  flush,
  output logic                  stall_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     write_data_out,
  output logic [DATA_W-1:0]     branch_target_out,
  output logic                  zero_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  MemWrite_out,
  output logic                  MemRead_out,
  output logic                  Branch_out,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic                  valid_out
);
  import mips_pkg::*;

  logic                     [DATA_W-1:0]     operand_b_p0;
  logic signed              [DATA_W-1:0]     a_s_p0;
  logic signed              [DATA_W-1:0]     b_s_p0;
  logic                     [DATA_W-1:0]     alu_result_p0;
  logic                     [DATA_W-1:0]     branch_target_p0;
  logic                     [REG_ADDR_W-1:0] write_reg_p0;
  logic                                      is_mul_p0;
  logic                                      mul_start;
  logic                                      mul_busy;
  logic                                      mul_done;
  logic                     [DATA_W-1:0]     mul_product;

  logic [DATA_W-1:0]     alu_result_p1;
  logic [DATA_W-1:0]     write_data_p1;
  logic [DATA_W-1:0]     branch_target_p1;
  logic                  zero_p1;
  logic [REG_ADDR_W-1:0] write_reg_p1;
  logic                  mem_write_p1;
  logic                  mem_read_p1;
  logic                  branch_p1;
  logic                  reg_write_p1;
  logic                  mem_to_reg_p1;
  logic                  vld_p1;

  // ---- Stage p0: operand select, ALU, branch target ----
  assign operand_b_p0     = ALUSrc ? sign_ext_imm : read_data_2;
  assign a_s_p0           = read_data_1;
  assign b_s_p0           = operand_b_p0;
  assign write_reg_p0     = RegDst ? rd_addr : rt_addr;
  assign branch_target_p0 = pc_plus_2 + {sign_ext_imm[DATA_W-2:0], 1'b0};
  assign is_mul_p0        = (ALUOp == ALU_MUL);
  assign mul_start        = in_valid && is_mul_p0;

  // Single-cycle ALU; MUL is produced by the sequential multiplier instead
  always_comb begin
    alu_result_p0 = '0;
    case (ALUOp)
      ALU_ADD:   alu_result_p0 = read_data_1 + operand_b_p0;
      ALU_SUB:   alu_result_p0 = read_data_1 - operand_b_p0;
      ALU_AND:   alu_result_p0 = read_data_1 & operand_b_p0;
      ALU_OR:    alu_result_p0 = read_data_1 | operand_b_p0;
      ALU_NOR:   alu_result_p0 = ~(read_data_1 | operand_b_p0);
      ALU_SLT:   alu_result_p0 = (a_s_p0 < b_s_p0) ? DATA_W'(1) : '0;
      ALU_PASSB: alu_result_p0 = operand_b_p0;
      default:   alu_result_p0 = '0;
    endcase
  end

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (read_data_1),
    .b       (operand_b_p0),
    .abort   (flush),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Hold upstream while a multiply launches or iterates; a flush releases it
  assign stall_out = !flush && (mul_busy || (!mul_done && mul_start));

  // ---- Stage p1: EX/MEM register ----
  // Bubble on flush, launch and BUSY; product emitted from DONE; otherwise ALU result
  always_ff @(posedge clk) begin
    if (rst || flush || mul_busy || (!mul_done && mul_start) || (!mul_done && !in_valid)) begin
      alu_result_p1    <= '0;
      write_data_p1    <= '0;
      branch_target_p1 <= '0;
      zero_p1          <= 1'b0;
      write_reg_p1     <= '0;
      mem_write_p1     <= 1'b0;
      mem_read_p1      <= 1'b0;
      branch_p1        <= 1'b0;
      reg_write_p1     <= 1'b0;
      mem_to_reg_p1    <= 1'b0;
      vld_p1           <= 1'b0;
    end else begin
      alu_result_p1    <= mul_done ? mul_product : alu_result_p0;
      zero_p1          <= mul_done ? (mul_product == '0) : (alu_result_p0 == '0);
      write_data_p1    <= read_data_2;
      branch_target_p1 <= branch_target_p0;
      write_reg_p1     <= write_reg_p0;
      mem_write_p1     <= MemWrite;
      mem_read_p1      <= MemRead;
      branch_p1        <= Branch;
      reg_write_p1     <= RegWrite;
      mem_to_reg_p1    <= MemtoReg;
      vld_p1           <= 1'b1;
    end
  end

  assign alu_result_out    = alu_result_p1;
  assign write_data_out    = write_data_p1;
  assign branch_target_out = branch_target_p1;
  assign zero_out          = zero_p1;
  assign write_reg_out     = write_reg_p1;
  assign MemWrite_out      = mem_write_p1;
  assign MemRead_out       = mem_read_p1;
  assign Branch_out        = branch_p1;
  assign RegWrite_out      = reg_write_p1;
  assign MemtoReg_out      = mem_to_reg_p1;
  assign valid_out         = vld_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, branch target, sequential
// multiply stall/latency, flush abort and reset during a multiply.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] read_data_1, read_data_2, sign_ext_imm, pc_plus_2;
  logic [2:0]  rt_addr, rd_addr;
  logic        RegDst, ALUSrc, MemWrite, MemRead, Branch, RegWrite, MemtoReg;
  logic [2:0]  ALUOp;
  logic        flush;
  logic        stall_out;
  logic [15:0] alu_result_out, write_data_out, branch_target_out;
  logic        zero_out;
  logic [2:0]  write_reg_out;
  logic        MemWrite_out, MemRead_out, Branch_out, RegWrite_out, MemtoReg_out, valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .read_data_1       (read_data_1),
    .read_data_2       (read_data_2),
    .sign_ext_imm      (sign_ext_imm),
    .pc_plus_2         (pc_plus_2),
    .rt_addr           (rt_addr),
    .rd_addr           (rd_addr),
    .RegDst            (RegDst),
    .ALUSrc            (ALUSrc),
    .MemWrite          (MemWrite),
    .MemRead           (MemRead),
    .Branch            (Branch),
    .RegWrite          (RegWrite),
    .MemtoReg          (MemtoReg),
    .ALUOp             (ALUOp),
    .flush             (flush),
    .stall_out         (stall_out),
    .alu_result_out    (alu_result_out),
    .write_data_out    (write_data_out),
    .branch_target_out (branch_target_out),
    .zero_out          (zero_out),
    .write_reg_out     (write_reg_out),
    .MemWrite_out      (MemWrite_out),
    .MemRead_out       (MemRead_out),
    .Branch_out        (Branch_out),
    .RegWrite_out      (RegWrite_out),
    .MemtoReg_out      (MemtoReg_out),
    .valid_out         (valid_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    in_valid = 0; read_data_1 = 0; read_data_2 = 0; sign_ext_imm = 0; pc_plus_2 = 0;
    rt_addr = 0; rd_addr = 0; RegDst = 0; ALUSrc = 0; MemWrite = 0; MemRead = 0;
    Branch = 0; RegWrite = 0; MemtoReg = 0; ALUOp = 3'b000; flush = 0;
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    clear_inputs();
    in_valid = 1; ALUOp = op; read_data_1 = a; read_data_2 = b; RegWrite = 1;
  endtask

  // Full multiply: stall for cycles 0..16, bubbles in 1..17, product in 18
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    alu_op(3'b110, a, b);
    RegDst = 1; rd_addr = 3'd3;
    #1;
    for (int c = 0; c <= 17; c++) begin
      check_eq($sformatf("mul_stall_c%0d", c), stall_out, (c <= 16));
      step();
      if (c < 17) check_eq($sformatf("mul_bubble_c%0d", c + 1), valid_out, 1'b0);
    end
    check_eq("mul_result", alu_result_out, exp);
    check_eq("mul_valid", valid_out, 1'b1);
    check_eq("mul_wreg", write_reg_out, 3'd3);
    check_eq("mul_regwrite", RegWrite_out, 1'b1);
    clear_inputs();
  endtask

  initial begin
    int seen_valid;
    clear_inputs();
    rst = 1;
    step();
    step();
    // Reset state
    check_eq("rst_alu", alu_result_out, 16'h0);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_stall", stall_out, 1'b0);
    check_eq("rst_ctrl", {MemWrite_out, MemRead_out, Branch_out, RegWrite_out, MemtoReg_out}, 5'b0);
    rst = 0;

    // ADD wraps into the sign bit
    alu_op(3'b000, 16'h7FFF, 16'h0001);
    RegDst = 1; rd_addr = 3'd5; rt_addr = 3'd2;
    step();
    check_eq("add_result", alu_result_out, 16'h8000);
    check_eq("add_zero", zero_out, 1'b0);
    check_eq("add_valid", valid_out, 1'b1);
    check_eq("add_wreg", write_reg_out, 3'd5);

    // SUB equal operands, branch target wraps backwards
    alu_op(3'b001, 16'h1234, 16'h1234);
    RegWrite = 0; Branch = 1; sign_ext_imm = 16'hFFFE; pc_plus_2 = 16'h0002; rt_addr = 3'd6;
    step();
    check_eq("sub_result", alu_result_out, 16'h0000);
    check_eq("sub_zero", zero_out, 1'b1);
    check_eq("sub_btgt", branch_target_out, 16'hFFFE);
    check_eq("sub_branch", Branch_out, 1'b1);
    check_eq("sub_wdata", write_data_out, 16'h1234);
    check_eq("sub_wreg_rt", write_reg_out, 3'd6);

    // PASSB with immediate operand
    alu_op(3'b111, 16'h5555, 16'h1111);
    ALUSrc = 1; sign_ext_imm = 16'h00AB;
    step();
    check_eq("passb_imm", alu_result_out, 16'h00AB);

    // NOR
    alu_op(3'b100, 16'hF0F0, 16'h0F00);
    step();
    check_eq("nor_result", alu_result_out, 16'h000F);

    // SLT signed, both orders
    alu_op(3'b101, 16'hFFFF, 16'h0001);
    step();
    check_eq("slt_lt", alu_result_out, 16'h0001);
    alu_op(3'b101, 16'h0001, 16'hFFFF);
    step();
    check_eq("slt_ge", alu_result_out, 16'h0000);
    check_eq("slt_ge_zero", zero_out, 1'b1);

    // Invalid slot registers as a bubble
    alu_op(3'b000, 16'h0001, 16'h0001);
    in_valid = 0; MemWrite = 1;
    step();
    check_eq("inv_valid", valid_out, 1'b0);
    check_eq("inv_ctrl", {MemWrite_out, RegWrite_out}, 2'b00);

    // MUL 300*300 = 90000 mod 65536
    run_mul(16'd300, 16'd300, 16'h5F90);

    // Flush in cycle 5 of a multiply
    alu_op(3'b110, 16'd7, 16'd9);
    for (int c = 0; c < 5; c++) step();
    flush = 1;
    #1;
    check_eq("flush_stall", stall_out, 1'b0);
    step();
    check_eq("flush_valid", valid_out, 1'b0);
    alu_op(3'b000, 16'd2, 16'd3);
    #1;
    check_eq("post_flush_stall", stall_out, 1'b0);
    step();
    check_eq("post_flush_add", alu_result_out, 16'd5);
    check_eq("post_flush_valid", valid_out, 1'b1);
    clear_inputs();
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (valid_out) seen_valid++;
    end
    check_eq("flush_no_product", seen_valid, 0);

    // Reset in the middle of BUSY
    alu_op(3'b110, 16'd300, 16'd300);
    for (int c = 0; c < 6; c++) step();
    rst = 1;
    step();
    rst = 0;
    clear_inputs();
    #1;
    check_eq("midrst_stall", stall_out, 1'b0);
    check_eq("midrst_valid", valid_out, 1'b0);
    check_eq("midrst_alu", alu_result_out, 16'h0);
    run_mul(16'd3, 16'd5, 16'h000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 16-bit pipelined MIPS, between the ID/EX register and the memory stage.
- Performs single-cycle ALU operations and a 16-iteration shift-add multiply.
- Computes the branch target and owns the EX/MEM pipeline register.
- Every registered output feeds the memory stage address, write data, branch and zero inputs, and passes the writeback controls forward.

Parameters:
- DATA_W, 16, datapath width.
- REG_ADDR_W, 3, register-file index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  ID/EX holds a real instruction.
- read_data_1  in  16  operand A.
- read_data_2  in  16  operand B and store data.
- sign_ext_imm  in  16  sign-extended immediate.
- pc_plus_2  in  16  PC of the instruction + 2.
- rt_addr, rd_addr  in  3 each  destination candidates.
- RegDst, ALUSrc, MemWrite, MemRead, Branch, RegWrite, MemtoReg  in  1 each  decoded controls.
- ALUOp  in  3  operation code.
- flush  in  1  kill the instruction in EX (taken branch).
- stall_out  out  1  hazard unit holds PC, IF/ID and ID/EX.
- alu_result_out  out  16  EX/MEM ALU result and memory address.
- write_data_out  out  16  EX/MEM store data (read_data_2).
- branch_target_out  out  16  EX/MEM branch target.
- zero_out  out  1  EX/MEM zero flag.
- write_reg_out  out  3  EX/MEM destination register.
- MemWrite_out, MemRead_out, Branch_out, RegWrite_out, MemtoReg_out, valid_out  out  1 each  EX/MEM controls.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, multiplier registers 0.
- Operand B = ALUSrc ? sign_ext_imm : read_data_2.
- write_reg = RegDst ? rd_addr : rt_addr.
- ALUOp codes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR.
  - 101 SLT: signed two's complement; result 16'h0001 or 16'h0000.
  - 110 MUL: low 16 bits of the unsigned product.
  - 111 PASSB: result = B.
  - ADD, SUB and MUL wrap modulo 2^16 and produce no overflow flag.
- zero = (result == 0) for every op.
- branch_target = pc_plus_2 + (sign_ext_imm << 1), wrapping modulo 2^16.
- Non-MUL instruction (or in_valid=0) in IDLE:
  - Captured into EX/MEM at the next edge; latency 1 cycle.
  - valid_out = in_valid.
  - When in_valid=0, all control outputs register as 0.
- FSM states: IDLE, BUSY, DONE.
- Cycle 0: IDLE with in_valid=1 and ALUOp=110.
  - stall_out=1 combinationally.
  - Edge ending cycle 0: load A and B, acc=0, count=0, go to BUSY; EX/MEM takes a bubble.
- BUSY, cycles 1..16:
  - stall_out=1.
  - Each edge: if multiplier bit 0 is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - The edge at count==15 moves to DONE.
  - EX/MEM takes a bubble at every BUSY edge.
- DONE, cycle 17:
  - stall_out=0.
  - Edge: EX/MEM captures acc as alu_result_out with the held MUL instruction's controls, valid_out=1; go to IDLE.
  - The MUL in ID/EX is not restarted.
- Totals: stall_out high for exactly 17 cycles; MUL result visible in cycle 18.
- Bubble: valid_out and all control outputs 0; data outputs don't-care, driven 0.
- flush=1 at an edge:
  - EX/MEM takes a bubble; FSM goes to IDLE, aborting any multiply; stall_out=0 in that cycle.
- Priority: rst > flush > FSM.
- Reset during BUSY or DONE behaves identically to power-on reset.
- in_valid=0 while BUSY: ignored, the multiply continues. The upstream requirement is to hold its inputs while stall_out=1.
- stall_out never depends on flush-gated registered state; it is combinational from state, in_valid, ALUOp and flush.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and REG_ADDR_W constants.
  - ALUOp localparams (ALU_ADD..ALU_PASSB).
  - FSM state encoding.
- Sub-module seq_multiplier:
  - Ports: start, a, b, abort, busy, done, product.
  - Contains the IDLE/BUSY/DONE FSM and counter.
  - execute_stage instantiates it and owns the EX/MEM register and stall logic.

Test Plan:
- ADD: A=16'h7FFF, B=1, ALUSrc=0 → next cycle alu_result_out=16'h8000, zero_out=0, valid_out=1.
- SUB: A=B=16'h1234 with Branch=1, imm=16'hFFFE, pc_plus_2=16'h0002 → alu_result_out=0, zero_out=1, branch_target_out=16'hFFFE, Branch_out=1.
- SLT: A=16'hFFFF (-1), B=16'h0001 → alu_result_out=16'h0001. Swapped operands → 16'h0000.
- MUL: A=300, B=300 → stall_out high cycles 0..16, bubbles (valid_out=0) during cycles 1..17, alu_result_out=16'h5F90 (24464) with valid_out=1 in cycle 18.
- flush asserted in cycle 5 of a MUL → FSM IDLE, stall_out=0 in cycle 5, valid_out=0 after the edge, no product ever emitted. The next ADD completes in 1 cycle.
- rst asserted during BUSY → all outputs 0 and stall_out=0 next cycle. A following MUL 3*5 yields 16'h000F after the full 17-cycle stall.
